seq_chunk_adder: RTL

Parametrised multi-cycle adder/subtractor, the successor to the 32-bit ripple-carry adder. Each cycle it adds one CHUNK-bit slice of the operands, LSB slice first, and carries between slices in a register. WIDTH, CHUNK and add/sub mode are configurable. Valid/ready handshakes on input and output let the ALU/multi-cycle datapath trade latency for a shorter carry chain. It also produces carry, signed-overflow and zero flags.

---
 rtl/seq_chunk_adder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor. One CHUNK-bit slice is added per clock,
// least-significant slice first, with the inter-slice carry held in a
// register. Valid/ready handshakes on both sides; flags are produced on the
// edge that completes the final slice.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Counter is at least one bit wide so CHUNK == WIDTH still elaborates.
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_sl [NCHUNK];
  logic [CHUNK-1:0] b_sl [NCHUNK];
  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] sum_nx;

  // Slice views of the operand registers, and the running sum with the
  // currently selected slice replaced by this cycle's result.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_sl[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_sl[gi] = b_q[gi*CHUNK +: CHUNK];
    assign sum_nx[gi*CHUNK +: CHUNK] =
      (cnt_q == CW'(gi)) ? slice_res[CHUNK-1:0] : sum_q[gi*CHUNK +: CHUNK];
  end

  // The only adder in the block: CHUNK+1 bits, carry-in from the register.
  assign slice_res = {1'b0, a_sl[cnt_q]} + {1'b0, b_sl[cnt_q]} + {{CHUNK{1'b0}}, c_q};

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  // Next-state and datapath update; every register holds unless told otherwise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d = sum_nx;
        c_d   = slice_res[CHUNK];
        if (cnt_q == LAST) begin
          carry_d    = slice_res[CHUNK];
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
          zero_d     = (sum_nx == '0);
          cnt_d      = '0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

endmodule
